// File: rtl/vga_sync_timing.sv
// 640x480@60 VGA raster timing driven by an edge-detected pixel-clock enable.
// Optional FrameCount output when VGA_FRAME_COUNT_EN is defined.
module vga_sync_timing #(
  parameter int   CountSize  = 10,
  parameter int   HVisible   = 640,
  parameter int   HFront     = 16,
  parameter int   HSyncLen   = 96,
  parameter int   HBack      = 48,
  parameter int   VVisible   = 480,
  parameter int   VFront     = 10,
  parameter int   VSyncLen   = 2,
  parameter int   VBack      = 33,
  parameter logic SyncActive = 1'b0
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_PixelClock,
  output logic [CountSize-1:0] o_HCount,
  output logic [CountSize-1:0] o_VCount,
  output logic                 o_HSync,
  output logic                 o_VSync,
  output logic                 o_VideoOn,
  output logic                 o_LineStart,
  output logic                 o_FrameStart
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]          o_FrameCount
`endif
);

  localparam int HTotal = HVisible + HFront + HSyncLen + HBack;
  localparam int VTotal = VVisible + VFront + VSyncLen + VBack;

  localparam logic [CountSize-1:0] H_LAST       = CountSize'(HTotal - 1);
  localparam logic [CountSize-1:0] V_LAST       = CountSize'(VTotal - 1);
  localparam logic [CountSize-1:0] H_VIS        = CountSize'(HVisible);
  localparam logic [CountSize-1:0] V_VIS        = CountSize'(VVisible);
  localparam logic [CountSize-1:0] H_SYNC_START = CountSize'(HVisible + HFront);
  localparam logic [CountSize-1:0] H_SYNC_END   = CountSize'(HVisible + HFront + HSyncLen);
  localparam logic [CountSize-1:0] V_SYNC_START = CountSize'(VVisible + VFront);
  localparam logic [CountSize-1:0] V_SYNC_END   = CountSize'(VVisible + VFront + VSyncLen);
  localparam logic [CountSize-1:0] ONE          = CountSize'(1);

  logic                 r_pix_q;
  logic [CountSize-1:0] r_hcount;
  logic [CountSize-1:0] r_vcount;
  logic                 r_hsync;
  logic                 r_vsync;
  logic                 r_video_on;
  logic                 r_line_start;
  logic                 r_frame_start;

  logic                 w_tick;
  logic                 w_line_wrap;
  logic                 w_frame_wrap;
  logic [CountSize-1:0] w_h_next;
  logic [CountSize-1:0] w_v_next;

  assign w_tick = i_PixelClock & ~r_pix_q;

  always_comb begin
    w_h_next     = r_hcount;
    w_v_next     = r_vcount;
    w_line_wrap  = 1'b0;
    w_frame_wrap = 1'b0;
    if (w_tick) begin
      if (r_hcount == H_LAST) begin
        w_h_next    = '0;
        w_line_wrap = 1'b1;
        if (r_vcount == V_LAST) begin
          w_v_next     = '0;
          w_frame_wrap = 1'b1;
        end else begin
          w_v_next = r_vcount + ONE;
        end
      end else begin
        w_h_next = r_hcount + ONE;
      end
    end
  end

  // Decode from next-state counters so every registered output matches the new position.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_pix_q       <= 1'b1;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= ~SyncActive;
      r_vsync       <= ~SyncActive;
      r_video_on    <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_q       <= i_PixelClock;
      r_hcount      <= w_h_next;
      r_vcount      <= w_v_next;
      r_hsync       <= ((w_h_next >= H_SYNC_START) && (w_h_next < H_SYNC_END)) ?
                       SyncActive : ~SyncActive;
      r_vsync       <= ((w_v_next >= V_SYNC_START) && (w_v_next < V_SYNC_END)) ?
                       SyncActive : ~SyncActive;
      r_video_on    <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
      r_line_start  <= w_line_wrap;
      r_frame_start <= w_frame_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_frame_count <= '0;
    end else if (w_frame_wrap) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign o_FrameCount = r_frame_count;
`endif

  assign o_HCount     = r_hcount;
  assign o_VCount     = r_vcount;
  assign o_HSync      = r_hsync;
  assign o_VSync      = r_vsync;
  assign o_VideoOn    = r_video_on;
  assign o_LineStart  = r_line_start;
  assign o_FrameStart = r_frame_start;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Scoreboard bench for vga_sync_timing; the vertical timing is shortened
// (13 lines, VSync on lines 8..9) so a full frame wrap fits in a short run.
module tb_vga_sync_timing;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pc = 1'b0;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  always #5 clk = ~clk;

  vga_sync_timing #(
    .VVisible (6),
    .VFront   (2),
    .VSyncLen (2),
    .VBack    (3)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst_n),
    .i_PixelClock (pc),
    .o_HCount     (hcount),
    .o_VCount     (vcount),
    .o_HSync      (hsync),
    .o_VSync      (vsync),
    .o_VideoOn    (video_on),
    .o_LineStart  (line_start),
    .o_FrameStart (frame_start)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .o_FrameCount (frame_count)
`endif
  );

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        vid;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  obs_t sb[$];
  int   checks = 0;
  int   failures = 0;

  int          m_h;
  int          m_v;
  logic        m_pq;
  logic        m_ls;
  logic        m_fs;
  logic [15:0] m_fc;

  function automatic obs_t model_out();
    obs_t o;
    o.h   = 10'(m_h);
    o.v   = 10'(m_v);
    o.hs  = !((m_h >= 656) && (m_h < 752));
    o.vs  = !((m_v >= 8) && (m_v < 10));
    o.vid = (m_h < 640) && (m_v < 6);
    o.ls  = m_ls;
    o.fs  = m_fs;
    o.fc  = m_fc;
    return o;
  endfunction

  function automatic obs_t dut_out();
    obs_t o;
    o.h   = hcount;
    o.v   = vcount;
    o.hs  = hsync;
    o.vs  = vsync;
    o.vid = video_on;
    o.ls  = line_start;
    o.fs  = frame_start;
`ifdef VGA_FRAME_COUNT_EN
    o.fc  = frame_count;
`else
    o.fc  = 16'd0;
`endif
    return o;
  endfunction

  function automatic logic is_key(obs_t e, logic prev_ls);
    return e.ls || prev_ls ||
           (e.h inside {10'd0, 10'd1, 10'd639, 10'd640, 10'd655, 10'd656,
                        10'd751, 10'd752, 10'd799});
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_pq = 1'b1; m_ls = 1'b0; m_fs = 1'b0; m_fc = 16'd0;
  endtask

  // Drive the pixel clock, advance the model and push what the next edge must produce.
  task automatic drive(input logic p);
    logic tick;
    pc = p;
    if (!rst_n) begin
      model_reset();
    end else begin
      tick = p & ~m_pq;
      m_pq = p;
      m_ls = 1'b0;
      m_fs = 1'b0;
      if (tick) begin
        if (m_h == 799) begin
          m_h  = 0;
          m_ls = 1'b1;
          if (m_v == 12) begin
            m_v  = 0;
            m_fs = 1'b1;
`ifdef VGA_FRAME_COUNT_EN
            m_fc = m_fc + 16'd1;
`endif
          end else begin
            m_v = m_v + 1;
          end
        end else begin
          m_h = m_h + 1;
        end
      end
    end
    sb.push_back(model_out());
  endtask

  task automatic advance(input logic p, output obs_t e, output obs_t g);
    drive(p);
    @(negedge clk);
    g = dut_out();
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    obs_t e, g;
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      advance(1'(i % 2), e, g);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, g, e);
      end
    end
    advance(1'b1, e, g);
    rst_n = 1'b1;
  endtask

  task automatic test_hold_high();
    obs_t e, g;
    for (int i = 0; i < 50; i++) begin
      advance(1'b1, e, g);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL hold_high cyc=%0d got=%h exp=%h", i, g, e);
      end
    end
    checks++;
    if (g.h !== 10'd0 || g.v !== 10'd0) begin
      failures++;
      $display("FAIL hold_high_counts got h=%0d v=%0d exp h=0 v=0", g.h, g.v);
    end
  endtask

  task automatic test_divide4();
    obs_t e, g;
    for (int i = 0; i < 40; i++) begin
      advance(((i % 4) < 2) ? 1'b0 : 1'b1, e, g);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL divide4 cyc=%0d got=%h exp=%h", i, g, e);
      end
    end
    checks++;
    if (g.h !== 10'd10) begin
      failures++;
      $display("FAIL divide4_count got h=%0d exp h=10", g.h);
    end
  endtask

  // Fast pixel clock (tick every 2 Clocks) until the first line wrap.
  task automatic test_line_timing();
    obs_t e, g;
    logic prev_ls = 1'b0;
    logic seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      advance(~pc, e, g);
      if (is_key(e, prev_ls)) begin
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL line_timing h=%0d v=%0d got=%h exp=%h", e.h, e.v, g, e);
        end
      end
      if (e.ls) begin
        seen = 1'b1;
        checks++;
        if (g.h !== 10'd0 || g.v !== 10'd1 || g.ls !== 1'b1 || g.fs !== 1'b0) begin
          failures++;
          $display("FAIL line_wrap got h=%0d v=%0d ls=%b fs=%b exp h=0 v=1 ls=1 fs=0",
                   g.h, g.v, g.ls, g.fs);
        end
      end
      prev_ls = e.ls;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL line_timing_timeout no line wrap within budget");
    end
  endtask

  task automatic test_frame_wrap();
    obs_t e, g;
    logic prev_ls = 1'b0;
    int   after = -1;
    for (int i = 0; i < 25000 && after != 0; i++) begin
      advance(~pc, e, g);
      if (is_key(e, prev_ls)) begin
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL frame_run h=%0d v=%0d got=%h exp=%h", e.h, e.v, g, e);
        end
      end
      if (e.fs) begin
        after = 4;
        checks++;
        if (g.h !== 10'd0 || g.v !== 10'd0 || g.ls !== 1'b1 || g.fs !== 1'b1 ||
            g.vs !== 1'b1 || g.vid !== 1'b1) begin
          failures++;
          $display("FAIL frame_wrap got h=%0d v=%0d ls=%b fs=%b vs=%b vid=%b exp 0 0 1 1 1 1",
                   g.h, g.v, g.ls, g.fs, g.vs, g.vid);
        end
`ifdef VGA_FRAME_COUNT_EN
        checks++;
        if (g.fc !== 16'd1) begin
          failures++;
          $display("FAIL frame_count got=%0d exp=1", g.fc);
        end
`endif
      end else if (after > 0) begin
        after--;
      end
      prev_ls = e.ls;
    end
    if (after != 0) begin
      checks++;
      failures++;
      $display("FAIL frame_wrap_timeout no frame wrap within budget");
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, g;
    obs_t rst_exp;
    logic hit = 1'b0;
    rst_exp = '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, vid: 1'b1,
                ls: 1'b0, fs: 1'b0, fc: 16'd0};
    for (int i = 0; i < 8000 && !hit; i++) begin
      advance(~pc, e, g);
      if (e.h == 10'd300 && e.v == 10'd2) hit = 1'b1;
    end
    checks++;
    if (!hit || g !== e) begin
      failures++;
      $display("FAIL reset_mid_reach hit=%b got=%h exp=%h", hit, g, e);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    g = dut_out();
    checks++;
    if (g !== rst_exp) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=%h", g, rst_exp);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) advance(~pc, e, g);
    advance(1'b1, e, g);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      advance(((i % 4) < 2) ? 1'b0 : 1'b1, e, g);
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reset_mid_resume cyc=%0d got=%h exp=%h", i, g, e);
      end
    end
    checks++;
    if (g.h !== 10'd3 || g.v !== 10'd0) begin
      failures++;
      $display("FAIL reset_mid_count got h=%0d v=%0d exp h=3 v=0", g.h, g.v);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_hold_high();
    test_divide4();
    test_line_timing();
    test_frame_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
